// File: rtl/min_tracker_pkg.sv
// Shared definitions for the stream minimum tracker.
//   state_t           FSM encoding: IDLE / ACCUM / HOLD
//   MINTRK_W          default sample width
//   MINTRK_FRAME_LEN  default maximum samples per frame
package min_tracker_pkg;

  localparam int MINTRK_W         = 5;
  localparam int MINTRK_FRAME_LEN = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/stream_min_tracker_if.sv
// Sample-in / result-out stream bundle for stream_min_tracker.
//   in_valid/in_ready/in_data/in_last     sample stream (source -> tracker)
//   out_valid/out_ready/out_min/out_cnt   result stream (tracker -> sink)
//   out_idx                               position of minimum, only when MINTRK_IDX_EN is defined
// Modports: slave = tracker side, master = source/sink side.
interface stream_min_tracker_if import min_tracker_pkg::*; #(
  parameter int W         = MINTRK_W,
  parameter int FRAME_LEN = MINTRK_FRAME_LEN
);
  localparam int IDX_W = $clog2(FRAME_LEN);

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_min;
  logic [IDX_W:0]   out_cnt;
`ifdef MINTRK_IDX_EN
  logic [IDX_W-1:0] out_idx;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_cnt, out_idx
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_cnt, out_idx
  );
`else
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_cnt
  );
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_cnt
  );
`endif

endinterface

// File: rtl/min_cmp_stage.sv
// Combinational compare/select slice for the running minimum.
//   first    : no running minimum yet, take the new sample unconditionally
//   a        : new sample          b     : running minimum
//   a_idx    : new sample index    b_idx : running minimum index (MINTRK_IDX_EN only)
//   sel_val  : selected minimum    sel_idx : selected index (MINTRK_IDX_EN only)
// Strict less-than keeps the earlier sample on ties. Swap this module for an
// approximate comparator variant without touching the tracker.
module min_cmp_stage import min_tracker_pkg::*; #(
  parameter int W = MINTRK_W
`ifdef MINTRK_IDX_EN
  , parameter int IDX_W = 3
`endif
) (
  input  logic             first,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
`ifdef MINTRK_IDX_EN
  input  logic [IDX_W-1:0] a_idx,
  input  logic [IDX_W-1:0] b_idx,
  output logic [IDX_W-1:0] sel_idx,
`endif
  output logic [W-1:0]     sel_val
);

  logic lt;
  logic take_a;

  assign lt      = (a < b);
  assign take_a  = first | lt;
  assign sel_val = take_a ? a : b;
`ifdef MINTRK_IDX_EN
  assign sel_idx = take_a ? a_idx : b_idx;
`endif

endmodule

// File: rtl/stream_min_tracker.sv
// Running-minimum tracker over framed sample stream; one result beat per frame.
// A frame ends on in_last or after FRAME_LEN samples.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   clr    : synchronous abort, drops partial frame and pending result
//   bus    : stream_min_tracker_if.slave (sample in, result out)
// Optional: define MINTRK_IDX_EN to add out_idx (first position of the minimum).
// W / FRAME_LEN must match the parameters of the connected interface.
//
// state | meaning
// IDLE  | waiting for first sample of a frame
// ACCUM | frame in progress, comparing each accepted sample
// HOLD  | result presented on out_*, input stalled until sink accepts
module stream_min_tracker import min_tracker_pkg::*; #(
  parameter int W         = MINTRK_W,
  parameter int FRAME_LEN = MINTRK_FRAME_LEN,
  parameter int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  stream_min_tracker_if.slave bus
);

  localparam int CNT_W = IDX_W + 1;
  // cnt holds samples taken so far, so the forced end is the beat seen at FRAME_LEN-1
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     min_q;
  logic [W-1:0]     out_min_q;
  logic [CNT_W-1:0] out_cnt_q;
  logic             accept;
  logic             frame_end;
  logic             first;
  logic [W-1:0]     sel_val;
`ifdef MINTRK_IDX_EN
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] out_idx_q;
  logic [IDX_W-1:0] sel_idx;
`endif

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_min   = out_min_q;
  assign bus.out_cnt   = out_cnt_q;
`ifdef MINTRK_IDX_EN
  assign bus.out_idx   = out_idx_q;
`endif

  // a beat offered alongside clr is dropped
  assign accept    = bus.in_valid & bus.in_ready & ~clr;
  assign first     = (state_q == IDLE);
  assign frame_end = bus.in_last | ((state_q == ACCUM) && (cnt_q == LAST_CNT));

  min_cmp_stage #(
    .W     (W)
`ifdef MINTRK_IDX_EN
    , .IDX_W (IDX_W)
`endif
  ) u_cmp (
    .first   (first),
    .a       (bus.in_data),
    .b       (min_q),
`ifdef MINTRK_IDX_EN
    .a_idx   (cnt_q[IDX_W-1:0]),
    .b_idx   (idx_q),
    .sel_idx (sel_idx),
`endif
    .sel_val (sel_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (accept) state_d = frame_end ? HOLD : ACCUM;
        ACCUM:   if (accept && frame_end) state_d = HOLD;
        HOLD:    if (bus.out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      min_q     <= '0;
      out_min_q <= '0;
      out_cnt_q <= '0;
`ifdef MINTRK_IDX_EN
      idx_q     <= '0;
      out_idx_q <= '0;
`endif
    end else if (clr) begin
      cnt_q <= '0;
    end else if (accept) begin
      min_q <= sel_val;
      cnt_q <= first ? CNT_W'(1) : cnt_q + 1'b1;
`ifdef MINTRK_IDX_EN
      idx_q <= sel_idx;
`endif
      // result registers load only on the beat that closes the frame
      if (frame_end) begin
        out_min_q <= sel_val;
        out_cnt_q <= first ? CNT_W'(1) : cnt_q + 1'b1;
`ifdef MINTRK_IDX_EN
        out_idx_q <= sel_idx;
`endif
      end
    end else if (state_q == HOLD && bus.out_ready) begin
      cnt_q <= '0;
    end
  end

endmodule
